// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the register-bus arbiter and the 32-source bus mux
// it feeds: source count, select width, select type and FSM encoding.
package bus_arbiter_pkg;

    localparam int N_SRC = 32;
    localparam int SEL_W = 5;

    // Select bus type, shared with the downstream mux.
    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot decode of a select value into a grant vector.
    function automatic logic [N_SRC-1:0] sel_onehot(input sel_t sel);
        logic [N_SRC-1:0] v;
        v = {N_SRC{1'b0}};
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner selection for the bus arbiter.
// Default build: round-robin, searching upward from ptr+1 with wrap 31->0, so
// the source at ptr itself has the lowest priority.
// With BUSARB_FIXED_PRIO_EN defined: plain priority encoder, lowest index wins,
// and the ptr input is absent.
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
`ifndef BUSARB_FIXED_PRIO_EN
    input  sel_t             ptr,
`endif
    output logic             any,
    output sel_t             winner
);

`ifndef BUSARB_FIXED_PRIO_EN
    sel_t idx_s;

    // Rotating search: walk offsets from farthest to nearest so the nearest
    // requester above ptr is the last (and therefore winning) assignment.
    always_comb begin
        any    = |req;
        winner = {SEL_W{1'b0}};
        idx_s  = {SEL_W{1'b0}};
        for (int i = N_SRC; i >= 1; i--) begin
            // Offset 32 truncates to 0 and addresses ptr itself.
            idx_s = ptr + SEL_W'(i);
            if (req[idx_s]) begin
                winner = idx_s;
            end else begin
                winner = winner;
            end
        end
    end
`else
    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        any    = |req;
        winner = {SEL_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = SEL_W'(i);
            end else begin
                winner = winner;
            end
        end
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Register-bus arbiter: serialises per-register read requests from 32 sources
// onto the shared bus, holding each grant for XFER_CYCLES beats and driving a
// registered select, one-hot grant and done/abort strobes.
// Optional build macro BUSARB_FIXED_PRIO_EN replaces round-robin with fixed
// priority (lowest index wins) and removes the rotation pointer.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int XFER_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      req,
    input  logic             bus_stall,
    output logic [4:0]       select,
    output logic [31:0]      grant,
    output logic             valid,
    output logic             xfer_done,
    output logic             xfer_abort
);

    // Counter value loaded at the start of each grant; counts down to zero.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XFER_CYCLES - 1);

    state_t             state_q,  state_d;
    sel_t               select_q, select_d;
    logic [N_SRC-1:0]   grant_q,  grant_d;
    logic               valid_q,  valid_d;
    logic               done_q,   done_d;
    logic               abort_q,  abort_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic               any_s;
    sel_t               winner_s;
    logic               load_s;

`ifndef BUSARB_FIXED_PRIO_EN
    sel_t               ptr_q,    ptr_d;
`endif

    bus_arbiter_rr_pick u_pick (
        .req    (req),
`ifndef BUSARB_FIXED_PRIO_EN
        .ptr    (ptr_q),
`endif
        .any    (any_s),
        .winner (winner_s)
    );

    // Next-state logic: new grants, stall hold, abort/done release and
    // back-to-back re-arbitration on the releasing edge.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        load_s   = 1'b0;
`ifndef BUSARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            GRANT: begin
                if (bus_stall) begin
                    // Everything freezes; a stall masks both completion and abort.
                    load_s = 1'b0;
                end else if (!req[select_q]) begin
                    // A drop on the final beat still counts as an abort.
                    abort_d = 1'b1;
                    if (any_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        grant_d = {N_SRC{1'b0}};
                    end
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    done_d = 1'b1;
                    if (any_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        grant_d = {N_SRC{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                grant_d = {N_SRC{1'b0}};
            end
        endcase

        // The pointer already equals the current select while granting, so the
        // picker output is the arbitration against the updated pointer.
        if (load_s) begin
            state_d  = GRANT;
            select_d = winner_s;
            grant_d  = sel_onehot(winner_s);
            valid_d  = 1'b1;
            cnt_d    = CNT_LOAD;
`ifndef BUSARB_FIXED_PRIO_EN
            ptr_d    = winner_s;
`endif
        end else begin
            load_s = 1'b0;
        end
    end

    // State and output registers; reset parks the pointer at 31 so source 0
    // has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            select_q <= {SEL_W{1'b0}};
            grant_q  <= {N_SRC{1'b0}};
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
`ifndef BUSARB_FIXED_PRIO_EN
            ptr_q    <= 5'd31;
`endif
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            cnt_q    <= cnt_d;
`ifndef BUSARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign select     = select_q;
    assign grant      = grant_q;
    assign valid      = valid_q;
    assign xfer_done  = done_q;
    assign xfer_abort = abort_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. Three instances share one clock:
// A (XFER_CYCLES=3) runs the vector table and the mid-transfer reset,
// B (XFER_CYCLES=2) the stall sequence, C (XFER_CYCLES=4) the early drop.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;

    logic [31:0] req_a, req_b, req_c;
    logic        stall_a, stall_b, stall_c;
    logic [4:0]  sel_a, sel_b, sel_c;
    logic [31:0] gnt_a, gnt_b, gnt_c;
    logic        vld_a, vld_b, vld_c;
    logic        done_a, done_b, done_c;
    logic        abort_a, abort_b, abort_c;

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.XFER_CYCLES(3), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .bus_stall(stall_a),
        .select(sel_a), .grant(gnt_a), .valid(vld_a),
        .xfer_done(done_a), .xfer_abort(abort_a));

    bus_arbiter #(.XFER_CYCLES(2), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .bus_stall(stall_b),
        .select(sel_b), .grant(gnt_b), .valid(vld_b),
        .xfer_done(done_b), .xfer_abort(abort_b));

    bus_arbiter #(.XFER_CYCLES(4), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .bus_stall(stall_c),
        .select(sel_c), .grant(gnt_c), .valid(vld_c),
        .xfer_done(done_c), .xfer_abort(abort_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] req;
        logic        stall;
        logic [4:0]  sel;
        logic [31:0] gnt;
        logic        vld;
        logic        done;
        logic        abort;
    } vec_t;

    vec_t tbl[20];

`ifdef BUSARB_FIXED_PRIO_EN
    localparam logic [4:0] P2 = 5'd1;
    localparam logic [4:0] P7 = 5'd1;
`else
    localparam logic [4:0] P2 = 5'd2;
    localparam logic [4:0] P7 = 5'd7;
`endif

    function automatic vec_t mk(input logic [31:0] r, input logic [4:0] s,
                                input logic [31:0] g, input logic v,
                                input logic d, input logic a);
        vec_t t;
        t.req = r; t.stall = 1'b0; t.sel = s; t.gnt = g;
        t.vld = v; t.done = d; t.abort = a;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 32'd0; req_b = 32'd0; req_c = 32'd0;
        stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;

        // Vector table for instance A (XFER_CYCLES=3).
        tbl[0]  = mk(32'h0,        5'd0,  32'h0,        1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(32'h00080000, 5'd19, 32'h00080000, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(32'h00080000, 5'd19, 32'h00080000, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(32'h00080000, 5'd19, 32'h00080000, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(32'h00080000, 5'd19, 32'h00080000, 1'b1, 1'b1, 1'b0);
        tbl[5]  = mk(32'h00080000, 5'd19, 32'h00080000, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(32'h00000086, 5'd1,  32'h00000002, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(32'h00000086, 5'd1,  32'h00000002, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(32'h00000086, 5'd1,  32'h00000002, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(32'h00000086, P2,    32'h1 << P2,  1'b1, 1'b1, 1'b0);
        tbl[10] = mk(32'h00000086, P2,    32'h1 << P2,  1'b1, 1'b0, 1'b0);
        tbl[11] = mk(32'h00000086, P2,    32'h1 << P2,  1'b1, 1'b0, 1'b0);
        tbl[12] = mk(32'h00000086, P7,    32'h1 << P7,  1'b1, 1'b1, 1'b0);
        tbl[13] = mk(32'h00000086, P7,    32'h1 << P7,  1'b1, 1'b0, 1'b0);
        tbl[14] = mk(32'h00000086, P7,    32'h1 << P7,  1'b1, 1'b0, 1'b0);
        tbl[15] = mk(32'h00000086, 5'd1,  32'h00000002, 1'b1, 1'b1, 1'b0);
        tbl[16] = mk(32'h00000086, 5'd1,  32'h00000002, 1'b1, 1'b0, 1'b0);
        tbl[17] = mk(32'h00000086, 5'd1,  32'h00000002, 1'b1, 1'b0, 1'b0);
        tbl[18] = mk(32'h0,        5'd1,  32'h0,        1'b0, 1'b0, 1'b1);
        tbl[19] = mk(32'h0,        5'd1,  32'h0,        1'b0, 1'b0, 1'b0);

        // Reset state, observed while reset is still asserted.
        #1;
        chk("rst_select", {27'd0, sel_a}, 32'd0);
        chk("rst_grant",  gnt_a, 32'd0);
        chk("rst_valid",  {31'd0, vld_a}, 32'd0);
        chk("rst_done",   {31'd0, done_a}, 32'd0);
        chk("rst_abort",  {31'd0, abort_a}, 32'd0);
        #11;
        rst_n = 1'b1;

        // Table-driven run on A: single request, back-to-back, round-robin, drain.
        for (int i = 0; i < 20; i++) begin
            req_a   = tbl[i].req;
            stall_a = tbl[i].stall;
            tick();
            chk($sformatf("tbl%0d_select", i), {27'd0, sel_a}, {27'd0, tbl[i].sel});
            chk($sformatf("tbl%0d_grant", i),  gnt_a, tbl[i].gnt);
            chk($sformatf("tbl%0d_valid", i),  {31'd0, vld_a}, {31'd0, tbl[i].vld});
            chk($sformatf("tbl%0d_done", i),   {31'd0, done_a}, {31'd0, tbl[i].done});
            chk($sformatf("tbl%0d_abort", i),  {31'd0, abort_a}, {31'd0, tbl[i].abort});
        end

        // Stall on B (XFER_CYCLES=2): grant source 2, then stall for 5 cycles.
        req_b = 32'h00000004;
        tick();
        chk("stall_grant0", gnt_b, 32'h00000004);
        stall_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_select", i), {27'd0, sel_b}, 32'd2);
            chk($sformatf("stall%0d_grant", i),  gnt_b, 32'h00000004);
            chk($sformatf("stall%0d_done", i),   {31'd0, done_b}, 32'd0);
        end
        stall_b = 1'b0;
        tick();
        chk("stall_post1_done", {31'd0, done_b}, 32'd0);
        tick();
        chk("stall_post2_done",  {31'd0, done_b}, 32'd1);
        chk("stall_post2_valid", {31'd0, vld_b}, 32'd1);
        req_b = 32'd0;

        // Early drop on C (XFER_CYCLES=4): source 7 granted, drops in beat 2.
        req_c = 32'h00000280;
        tick();
        chk("drop_select0", {27'd0, sel_c}, 32'd7);
        tick();
        chk("drop_beat2_abort", {31'd0, abort_c}, 32'd0);
        req_c = 32'h00000200;
        tick();
        chk("drop_abort",  {31'd0, abort_c}, 32'd1);
        chk("drop_done",   {31'd0, done_c}, 32'd0);
        chk("drop_select", {27'd0, sel_c}, 32'd9);
        chk("drop_grant",  gnt_c, 32'h00000200);
        chk("drop_valid",  {31'd0, vld_c}, 32'd1);
        tick();
        chk("drop_abort_once", {31'd0, abort_c}, 32'd0);
        chk("drop_no_done",    {31'd0, done_c}, 32'd0);
        req_c = 32'd0;

        // Asynchronous reset in the middle of a grant to source 7 on A.
        req_a = 32'h00000080;
        tick();
        chk("mrst_pre_select", {27'd0, sel_a}, 32'd7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_select", {27'd0, sel_a}, 32'd0);
        chk("mrst_grant",  gnt_a, 32'd0);
        chk("mrst_valid",  {31'd0, vld_a}, 32'd0);
        req_a = 32'd0;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_idle_grant", gnt_a, 32'd0);
        chk("mrst_idle_valid", {31'd0, vld_a}, 32'd0);
        chk("mrst_idle_select", {27'd0, sel_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
